// File: rtl/pipeimem_loader.sv
// Writable instruction memory for the pipelined MIPS core, filled from a byte stream.
// Bytes are packed big-endian into words and written to consecutive addresses; fetch is combinational.
module pipeimem_loader #(
  parameter int unsigned WORDS = 64
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [6:0]  len_words,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic [6:0]  word_count,
  output logic [31:0] checksum,
  input  logic [31:0] a,
  output logic [31:0] inst
);

  localparam int unsigned AW = $clog2(WORDS);
  localparam logic [6:0] MaxLen = 7'(WORDS);

  typedef enum logic [1:0] {StIdle, StLoad, StFinish} state_e;

  state_e      state;
  logic [6:0]  len_q;
  logic [1:0]  byte_idx;
  logic [23:0] shift_q;
  logic [31:0] mem [WORDS];

  logic [6:0]  lat_len;
  logic        accept;
  logic        word_we;
  logic [31:0] word_new;

  assign lat_len  = (len_words > MaxLen) ? MaxLen : len_words;
  assign accept   = byte_valid & byte_ready;
  assign word_we  = accept & (byte_idx == 2'd3);
  assign word_new = {shift_q, byte_data};
  assign cpu_hold = busy;

  // Outputs are registered alongside the state so they never depend on byte_valid.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= StIdle;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      len_q      <= 7'd0;
      word_count <= 7'd0;
      checksum   <= 32'd0;
      byte_idx   <= 2'd0;
      shift_q    <= 24'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            len_q      <= lat_len;
            word_count <= 7'd0;
            checksum   <= 32'd0;
            byte_idx   <= 2'd0;
            shift_q    <= 24'd0;
            busy       <= 1'b1;
            if (lat_len != 7'd0) begin
              state      <= StLoad;
              byte_ready <= 1'b1;
            end else begin
              state <= StFinish;
              done  <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (accept) begin
            if (byte_idx == 2'd3) begin
              word_count <= word_count + 7'd1;
              checksum   <= checksum + word_new;
              byte_idx   <= 2'd0;
              if (word_count + 7'd1 == len_q) begin
                state      <= StFinish;
                byte_ready <= 1'b0;
                done       <= 1'b1;
              end
            end else begin
              shift_q  <= {shift_q[15:0], byte_data};
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        StFinish: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Storage is deliberately not reset so completed words survive an aborted load.
  always_ff @(posedge clock) begin
    if (word_we) mem[word_count[AW-1:0]] <= word_new;
  end

  assign inst = mem[a[AW+1:2]];

  logic unused_a;
  assign unused_a = ^{a[31:AW+2], a[1:0]};

endmodule

// File: tb/tb_pipeimem_loader.sv
// Randomized scoreboard bench for pipeimem_loader: stimulus pushes expected done/fetch results,
// a negedge monitor pops and compares them against a word-level memory model.
module tb_pipeimem_loader;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [6:0]  len_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic [6:0]  word_count;
  logic [31:0] checksum;
  logic [31:0] a;
  logic [31:0] inst;

  pipeimem_loader #(.WORDS(64)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .len_words  (len_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .word_count (word_count),
    .checksum   (checksum),
    .a          (a),
    .inst       (inst)
  );

  typedef struct {
    logic [6:0]  wc;
    logic [31:0] cs;
    int          cyc;
  } done_t;

  done_t       done_q[$];
  logic [31:0] rd_q[$];
  logic        rd_en;
  logic [7:0]  stream[$];
  logic [31:0] ref_mem[64];
  bit          ref_known[64];
  int          cyc;
  int          nvec;
  int          nfail;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(string name);
    nvec++;
    nfail++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endfunction

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clock) begin
    if (resetn && done) begin
      if (done_q.size() == 0) begin
        fail_now("unexpected_done");
      end else begin
        done_t e;
        e = done_q.pop_front();
        chk("done_word_count", 32'(word_count), 32'(e.wc));
        chk("done_checksum", checksum, e.cs);
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_cpu_hold", 32'(cpu_hold), 32'd1);
      end
    end
    if (rd_en && rd_q.size() != 0) chk("inst", inst, rd_q.pop_front());
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_random(input int nbytes);
    stream.delete();
    for (int i = 0; i < nbytes; i++) stream.push_back(8'($urandom));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // mode: 0 continuous, 1 valid every other cycle, 2 random gaps.
  // stop_after < 4*len aborts the stream early (caller then resets).
  task automatic run_load(input int len_in, input int mode, input int stop_after,
                          input bit poke);
    int          n;
    int          sent;
    int          i;
    bit          v;
    bit          poked;
    logic [31:0] w;
    logic [31:0] cs;
    n     = (len_in > 64) ? 64 : len_in;
    sent  = 0;
    i     = 0;
    cs    = 32'd0;
    poked = 1'b0;
    start     = 1'b1;
    len_words = 7'(len_in);
    step();
    start = 1'b0;
    if (n == 0) done_q.push_back('{wc: 7'd0, cs: 32'd0, cyc: cyc});
    while (sent < 4 * n && sent < stop_after) begin
      chk("byte_ready_load", 32'(byte_ready), 32'd1);
      chk("busy_load", 32'(busy), 32'd1);
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = (i % 2 == 0);
      else v = ($urandom_range(0, 2) != 0);
      i++;
      byte_valid = v;
      byte_data  = v ? stream[sent] : 8'($urandom);
      if (poke && !poked && sent == 2) begin
        start     = 1'b1;
        len_words = 7'd5;
        poked     = 1'b1;
      end
      step();
      start = 1'b0;
      if (v) begin
        sent++;
        if (sent % 4 == 0) begin
          w = {stream[sent-4], stream[sent-3], stream[sent-2], stream[sent-1]};
          ref_mem[sent/4 - 1]   = w;
          ref_known[sent/4 - 1] = 1'b1;
          cs = cs + w;
          if (sent == 4 * n) done_q.push_back('{wc: 7'(n), cs: cs, cyc: cyc});
        end
      end
    end
    byte_valid = 1'b0;
    if (stop_after >= 4 * n) begin
      repeat (3) step();
      if (done_q.size() != 0) begin
        nvec++;
        nfail++;
        $display("FAIL done_missing: got no done expected %0d pending", done_q.size());
        done_q.delete();
      end
      check_idle_outputs("after_load");
      chk("final_word_count", 32'(word_count), 32'(n));
      chk("final_checksum", checksum, cs);
    end
  endtask

  task automatic sweep();
    logic [31:0] r;
    rd_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (ref_known[i]) begin
        r = $urandom;
        a = {r[31:8], 6'(i), r[1:0]};
        rd_q.push_back(ref_mem[i]);
        step();
      end
    end
    if (ref_known[1]) begin
      a = 32'h0000_0104;
      rd_q.push_back(ref_mem[1]);
      step();
    end
    rd_en = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    nvec       = 0;
    nfail      = 0;
    cyc        = 0;
    rd_en      = 1'b0;
    resetn     = 1'b0;
    start      = 1'b0;
    len_words  = 7'd0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    a          = 32'd0;
    for (int i = 0; i < 64; i++) ref_known[i] = 1'b0;
    #3;
    check_idle_outputs("reset");
    chk("reset_word_count", 32'(word_count), 32'd0);
    chk("reset_checksum", checksum, 32'd0);
    #24 resetn = 1'b1;
    step();

    // Basic two-word load, continuous stream.
    stream = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
    run_load(2, 0, 1 << 20, 1'b0);
    sweep();

    // Same stream, throttled source.
    run_load(2, 1, 1 << 20, 1'b0);
    sweep();

    // Empty load.
    run_load(0, 0, 1 << 20, 1'b0);
    sweep();

    // Saturation: 100 requested, 64 written; trailing bytes must be refused.
    fill_random(256);
    run_load(100, 2, 1 << 20, 1'b0);
    byte_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      byte_data = 8'($urandom);
      chk("byte_ready_after_sat", 32'(byte_ready), 32'd0);
      step();
    end
    byte_valid = 1'b0;
    chk("word_count_after_sat", 32'(word_count), 32'd64);
    sweep();

    // Abort after six bytes of a two-word load.
    fill_random(8);
    run_load(2, 0, 6, 1'b0);
    #2 resetn = 1'b0;
    #1;
    check_idle_outputs("abort");
    chk("abort_word_count", 32'(word_count), 32'd0);
    chk("abort_checksum", checksum, 32'd0);
    step();
    #2 resetn = 1'b1;
    step();
    byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      byte_data = 8'($urandom);
      chk("byte_ready_no_start", 32'(byte_ready), 32'd0);
      step();
    end
    byte_valid = 1'b0;
    chk("word_count_no_start", 32'(word_count), 32'd0);
    sweep();

    // One-word reload with a stray start pulse mid-load.
    fill_random(4);
    run_load(1, 0, 1 << 20, 1'b1);
    sweep();

    // Random lengths and gaps.
    for (int k = 0; k < 4; k++) begin
      int len;
      len = $urandom_range(0, 70);
      fill_random(4 * 64);
      run_load(len, 2, 1 << 20, 1'b0);
      sweep();
    end

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
